// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: wakeup/select scheduler for the reservation station.
// Tracks per-line state (FREE/WAIT/ISSUED) and source readiness. Each cycle it
// hands the oldest ready line to every functional unit over a valid/ready pair.

// Oldest-candidate picker for one functional unit.
module rs_fu_select #(
    parameter int RS_DEPTH = 16,
    parameter int LINE_W   = 4,
    parameter int AGE_W    = 4
) (
    input  logic [RS_DEPTH-1:0]            cand,
    input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
    output logic                           found,
    output logic [LINE_W-1:0]              line
);
    logic [AGE_W-1:0] best_age;

    // Linear min-age scan; ROB indices are unique, so ages never tie.
    always_comb begin
        found    = 1'b0;
        line     = '0;
        best_age = '1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && (!found || age[i] < best_age)) begin
                found    = 1'b1;
                line     = LINE_W'(i);
                best_age = age[i];
            end
        end
    end
endmodule

module rs_issue_scheduler #(
    parameter  int RS_DEPTH = 16,
    parameter  int PREG_W   = 6,
    parameter  int ROB_W    = 4,
    parameter  int NUM_FU   = 3,
    localparam int LINE_W   = $clog2(RS_DEPTH),
    localparam int CNT_W    = $clog2(RS_DEPTH + 1),
    localparam int FU_W     = $clog2(NUM_FU)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_en_1,
    input  logic                       alloc_en_2,
    input  logic [LINE_W-1:0]          alloc_line_1,
    input  logic [LINE_W-1:0]          alloc_line_2,
    input  logic [FU_W-1:0]            alloc_fu_1,
    input  logic [FU_W-1:0]            alloc_fu_2,
    input  logic [PREG_W-1:0]          alloc_ps1_1,
    input  logic [PREG_W-1:0]          alloc_ps1_2,
    input  logic [PREG_W-1:0]          alloc_ps2_1,
    input  logic [PREG_W-1:0]          alloc_ps2_2,
    input  logic                       alloc_rdy1_1,
    input  logic                       alloc_rdy1_2,
    input  logic                       alloc_rdy2_1,
    input  logic                       alloc_rdy2_2,
    input  logic [ROB_W-1:0]           alloc_rob_1,
    input  logic [ROB_W-1:0]           alloc_rob_2,
    input  logic [ROB_W-1:0]           rob_head,
    input  logic [NUM_FU-1:0]          wb_valid,
    input  logic [NUM_FU*PREG_W-1:0]   wb_pd,
    input  logic [NUM_FU-1:0]          fu_ready,
    output logic [NUM_FU-1:0]          issue_valid,
    output logic [NUM_FU*LINE_W-1:0]   issue_line,
    output logic [RS_DEPTH-1:0]        free_mask,
    output logic [CNT_W-1:0]           free_count,
    output logic                       rs_full,
    output logic                       alloc_err
);
    typedef enum logic [1:0] {E_FREE, E_WAIT, E_ISSUED} ent_st_t;

    typedef struct packed {
        logic              en;
        logic [LINE_W-1:0] line;
        logic [FU_W-1:0]   fu;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic              rdy1;
        logic              rdy2;
        logic [ROB_W-1:0]  rob;
    } alloc_req_t;

    // Registered per-line state and payload
    ent_st_t                         st_q [RS_DEPTH];
    logic [RS_DEPTH-1:0][FU_W-1:0]   fu_q;
    logic [RS_DEPTH-1:0][PREG_W-1:0] ps1_q, ps2_q;
    logic [RS_DEPTH-1:0][ROB_W-1:0]  rob_q;
    logic [RS_DEPTH-1:0]             rdy1_q, rdy2_q;
    logic [NUM_FU-1:0]               iv_q;
    logic [NUM_FU-1:0][LINE_W-1:0]   il_q;
    logic [RS_DEPTH-1:0]             fm_q;
    logic [CNT_W-1:0]                fc_q;
    logic                            err_q;

    // Next-state
    ent_st_t                         st_n [RS_DEPTH];
    logic [RS_DEPTH-1:0]             rdy1_n, rdy2_n;
    logic [NUM_FU-1:0]               iv_n;
    logic [NUM_FU-1:0][LINE_W-1:0]   il_n;
    logic [RS_DEPTH-1:0]             fm_n;
    logic [CNT_W-1:0]                fc_n;

    alloc_req_t [1:0]                req;
    logic [1:0]                      alloc_ok;
    logic                            alloc_bad;
    logic [NUM_FU-1:0][PREG_W-1:0]   wb_tag;
    logic [RS_DEPTH-1:0][ROB_W-1:0]  age;
    logic [NUM_FU-1:0][RS_DEPTH-1:0] cand;
    logic [NUM_FU-1:0]               sel_found;
    logic [NUM_FU-1:0][LINE_W-1:0]   sel_line;

    assign req[0] = {alloc_en_1, alloc_line_1, alloc_fu_1, alloc_ps1_1, alloc_ps2_1,
                     alloc_rdy1_1, alloc_rdy2_1, alloc_rob_1};
    assign req[1] = {alloc_en_2, alloc_line_2, alloc_fu_2, alloc_ps1_2, alloc_ps2_2,
                     alloc_rdy1_2, alloc_rdy2_2, alloc_rob_2};
    assign wb_tag = wb_pd;

    assign issue_valid = iv_q;
    assign issue_line  = il_q;
    assign free_mask   = fm_q;
    assign free_count  = fc_q;
    assign rs_full     = (fc_q < CNT_W'(2));
    assign alloc_err   = err_q;

    function automatic logic wb_hit(input logic [PREG_W-1:0] tag,
                                    input logic [NUM_FU-1:0] vld,
                                    input logic [NUM_FU-1:0][PREG_W-1:0] tags);
        logic hit = 1'b0;
        for (int f = 0; f < NUM_FU; f++) hit |= vld[f] && (tags[f] == tag);
        return hit;
    endfunction

    // Eligibility and age are taken from registered state only, so a wakeup
    // or allocation this cycle becomes selectable one cycle later.
    always_comb begin
        cand = '0;
        age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age[i] = rob_q[i] - rob_head;
            for (int f = 0; f < NUM_FU; f++)
                cand[f][i] = (st_q[i] == E_WAIT) && rdy1_q[i] && rdy2_q[i] &&
                             (fu_q[i] == FU_W'(f));
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        rs_fu_select #(.RS_DEPTH(RS_DEPTH), .LINE_W(LINE_W), .AGE_W(ROB_W)) u_sel (
            .cand  (cand[f]),
            .age   (age),
            .found (sel_found[f]),
            .line  (sel_line[f])
        );
    end

    // Allocation legality: target must be FREE in registered state, FU index
    // must exist, and port 2 loses a same-line collision with port 1.
    always_comb begin
        for (int p = 0; p < 2; p++)
            alloc_ok[p] = req[p].en && (st_q[req[p].line] == E_FREE) &&
                          (req[p].fu < FU_W'(NUM_FU));
        if (req[0].en && req[1].en && (req[0].line == req[1].line))
            alloc_ok[1] = 1'b0;
        alloc_bad = (req[0].en && !alloc_ok[0]) || (req[1].en && !alloc_ok[1]);
    end

    // Next-state: handshake free, select, wakeup and allocate touch disjoint
    // lines/fields, so applying them in sequence is order-independent.
    always_comb begin
        st_n   = st_q;
        rdy1_n = rdy1_q;
        rdy2_n = rdy2_q;
        iv_n   = iv_q;
        il_n   = il_q;
        for (int f = 0; f < NUM_FU; f++) begin
            if (iv_q[f] && fu_ready[f]) begin
                st_n[il_q[f]] = E_FREE;
                iv_n[f]       = 1'b0;
            end
            if ((!iv_q[f] || fu_ready[f]) && sel_found[f]) begin
                st_n[sel_line[f]] = E_ISSUED;
                iv_n[f]           = 1'b1;
                il_n[f]           = sel_line[f];
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (st_q[i] == E_WAIT) begin
                if (wb_hit(ps1_q[i], wb_valid, wb_tag)) rdy1_n[i] = 1'b1;
                if (wb_hit(ps2_q[i], wb_valid, wb_tag)) rdy2_n[i] = 1'b1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (alloc_ok[p]) begin
                st_n[req[p].line]   = E_WAIT;
                rdy1_n[req[p].line] = req[p].rdy1 || wb_hit(req[p].ps1, wb_valid, wb_tag);
                rdy2_n[req[p].line] = req[p].rdy2 || wb_hit(req[p].ps2, wb_valid, wb_tag);
            end
        end
    end

    // Free mask and population count derived from next-state.
    always_comb begin
        fm_n = '0;
        fc_n = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            fm_n[i] = (st_n[i] == E_FREE);
            fc_n    = fc_n + CNT_W'(st_n[i] == E_FREE);
        end
    end

    // Control state: reset over flush over normal update; flush keeps alloc_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) st_q[i] <= E_FREE;
            rdy1_q <= '0;
            rdy2_q <= '0;
            iv_q   <= '0;
            il_q   <= '0;
            fm_q   <= '1;
            fc_q   <= CNT_W'(RS_DEPTH);
            err_q  <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) st_q[i] <= E_FREE;
            iv_q <= '0;
            fm_q <= '1;
            fc_q <= CNT_W'(RS_DEPTH);
        end else begin
            st_q   <= st_n;
            rdy1_q <= rdy1_n;
            rdy2_q <= rdy2_n;
            iv_q   <= iv_n;
            il_q   <= il_n;
            fm_q   <= fm_n;
            fc_q   <= fc_n;
            if (alloc_bad) err_q <= 1'b1;
        end
    end

    // Payload is only meaningful while a line is occupied, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int p = 0; p < 2; p++) begin
                if (alloc_ok[p]) begin
                    fu_q[req[p].line]  <= req[p].fu;
                    ps1_q[req[p].line] <= req[p].ps1;
                    ps2_q[req[p].line] <= req[p].ps2;
                    rob_q[req[p].line] <= req[p].rob;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: a per-cycle vector table plus
// hand-written sequences for stall, full, error, flush and reset cases.
module tb_rs_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alloc_en_1, alloc_en_2;
    logic [3:0]  alloc_line_1, alloc_line_2;
    logic [1:0]  alloc_fu_1, alloc_fu_2;
    logic [5:0]  alloc_ps1_1, alloc_ps1_2, alloc_ps2_1, alloc_ps2_2;
    logic        alloc_rdy1_1, alloc_rdy1_2, alloc_rdy2_1, alloc_rdy2_2;
    logic [3:0]  alloc_rob_1, alloc_rob_2, rob_head;
    logic [2:0]  wb_valid, fu_ready, issue_valid;
    logic [17:0] wb_pd;
    logic [11:0] issue_line;
    logic [15:0] free_mask;
    logic [4:0]  free_count;
    logic        rs_full, alloc_err;

    always #5 clk = ~clk;

    rs_issue_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en_1(alloc_en_1), .alloc_en_2(alloc_en_2),
        .alloc_line_1(alloc_line_1), .alloc_line_2(alloc_line_2),
        .alloc_fu_1(alloc_fu_1), .alloc_fu_2(alloc_fu_2),
        .alloc_ps1_1(alloc_ps1_1), .alloc_ps1_2(alloc_ps1_2),
        .alloc_ps2_1(alloc_ps2_1), .alloc_ps2_2(alloc_ps2_2),
        .alloc_rdy1_1(alloc_rdy1_1), .alloc_rdy1_2(alloc_rdy1_2),
        .alloc_rdy2_1(alloc_rdy2_1), .alloc_rdy2_2(alloc_rdy2_2),
        .alloc_rob_1(alloc_rob_1), .alloc_rob_2(alloc_rob_2),
        .rob_head(rob_head), .wb_valid(wb_valid), .wb_pd(wb_pd),
        .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_line(issue_line),
        .free_mask(free_mask), .free_count(free_count), .rs_full(rs_full),
        .alloc_err(alloc_err)
    );

    typedef struct packed {
        logic       en;
        logic [3:0] line;
        logic [1:0] fu;
        logic [5:0] ps1, ps2;
        logic       r1, r2;
        logic [3:0] rob;
    } areq_t;

    typedef struct {
        areq_t       a1, a2;
        logic [3:0]  rh;
        logic [2:0]  wbv;
        logic [17:0] wbpd;
        logic [2:0]  fur;
        logic [2:0]  e_iv;
        logic [11:0] e_il;
        logic [4:0]  e_fc;
    } vec_t;

    localparam areq_t NA = '0;
    vec_t vt[$];
    int n_chk = 0, n_fail = 0;

    function automatic areq_t A(input logic [3:0] line, input logic [1:0] fu,
                                input logic [5:0] ps1, input logic r1,
                                input logic [5:0] ps2, input logic r2,
                                input logic [3:0] rob);
        areq_t a = '{en: 1'b1, line: line, fu: fu, ps1: ps1, ps2: ps2, r1: r1, r2: r2, rob: rob};
        return a;
    endfunction

    function automatic logic [17:0] wb(input int f, input logic [5:0] tag);
        logic [17:0] v = 18'(tag);
        return v << (6 * f);
    endfunction

    function automatic logic [11:0] il_mask(input logic [2:0] iv);
        logic [11:0] m = '0;
        for (int f = 0; f < 3; f++) if (iv[f]) m[4*f +: 4] = 4'hF;
        return m;
    endfunction

    task automatic addv(input areq_t a1, input areq_t a2, input logic [3:0] rh,
                        input logic [2:0] wbv, input logic [17:0] wbpd, input logic [2:0] fur,
                        input logic [2:0] e_iv, input logic [11:0] e_il, input logic [4:0] e_fc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.rh = rh; v.wbv = wbv; v.wbpd = wbpd; v.fur = fur;
        v.e_iv = e_iv; v.e_il = e_il; v.e_fc = e_fc;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input areq_t a1, input areq_t a2, input logic [3:0] rh,
                         input logic [2:0] wbv, input logic [17:0] wbpd,
                         input logic [2:0] fur, input logic fl);
        alloc_en_1 = a1.en; alloc_line_1 = a1.line; alloc_fu_1 = a1.fu;
        alloc_ps1_1 = a1.ps1; alloc_ps2_1 = a1.ps2; alloc_rdy1_1 = a1.r1;
        alloc_rdy2_1 = a1.r2; alloc_rob_1 = a1.rob;
        alloc_en_2 = a2.en; alloc_line_2 = a2.line; alloc_fu_2 = a2.fu;
        alloc_ps1_2 = a2.ps1; alloc_ps2_2 = a2.ps2; alloc_rdy1_2 = a2.r1;
        alloc_rdy2_2 = a2.r2; alloc_rob_2 = a2.rob;
        rob_head = rh; wb_valid = wbv; wb_pd = wbpd; fu_ready = fur; flush = fl;
    endtask

    task automatic idle(input logic [2:0] fur);
        drive(NA, NA, 4'd0, 3'b000, 18'd0, fur, 1'b0);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(3'b000);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(3'b000);

        // Table: plain issue, age order across rob wrap, bypass, wakeups
        addv(A(0,0,0,1,0,1,0), A(1,1,0,1,0,1,1), 0, 0, 0, 3'b000, 3'b000, 12'h000, 14);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b011, 12'h010, 14);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b011, 12'h010, 14);
        addv(NA, NA, 0, 0, 0, 3'b111, 3'b000, 12'h000, 16);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b000, 12'h000, 16);
        addv(A(4,0,0,1,0,1,15), A(5,0,0,1,0,1,2), 14, 0, 0, 3'b000, 3'b000, 12'h000, 14);
        addv(A(6,0,0,1,0,1,13), NA, 14, 0, 0, 3'b001, 3'b001, 12'h004, 13);
        addv(NA, NA, 14, 0, 0, 3'b001, 3'b001, 12'h005, 14);
        addv(NA, NA, 14, 0, 0, 3'b001, 3'b001, 12'h006, 15);
        addv(NA, NA, 14, 0, 0, 3'b001, 3'b000, 12'h000, 16);
        addv(A(2,2,20,0,21,1,3), NA, 0, 3'b001, wb(0,20), 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b100, 12'h200, 15);
        addv(NA, NA, 0, 0, 0, 3'b100, 3'b000, 12'h000, 16);
        addv(A(3,0,9,0,0,1,4), NA, 0, 0, 0, 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 3'b010, wb(1,10), 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 3'b000, wb(1,9), 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 3'b010, wb(1,9), 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b001, 12'h003, 15);
        addv(NA, NA, 0, 0, 0, 3'b001, 3'b000, 12'h000, 16);
        addv(A(11,1,5,1,7,0,5), NA, 0, 0, 0, 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 3'b100, wb(2,7), 3'b000, 3'b000, 12'h000, 15);
        addv(NA, NA, 0, 0, 0, 3'b000, 3'b010, 12'h0B0, 15);
        addv(NA, NA, 0, 0, 0, 3'b010, 3'b000, 12'h000, 16);

        // Reset values
        do_reset();
        chk("rst_iv", 32'(issue_valid), 0);
        chk("rst_il", 32'(issue_line), 0);
        chk("rst_mask", 32'(free_mask), 32'hFFFF);
        chk("rst_fc", 32'(free_count), 16);
        chk("rst_full", 32'(rs_full), 0);
        chk("rst_err", 32'(alloc_err), 0);

        foreach (vt[k]) begin
            drive(vt[k].a1, vt[k].a2, vt[k].rh, vt[k].wbv, vt[k].wbpd, vt[k].fur, 1'b0);
            step();
            chk($sformatf("v%0d_iv", k), 32'(issue_valid), 32'(vt[k].e_iv));
            chk($sformatf("v%0d_il", k), 32'(issue_line & il_mask(vt[k].e_iv)), 32'(vt[k].e_il));
            chk($sformatf("v%0d_fc", k), 32'(free_count), 32'(vt[k].e_fc));
            chk($sformatf("v%0d_full", k), 32'(rs_full), 32'(vt[k].e_fc < 2));
            chk($sformatf("v%0d_err", k), 32'(alloc_err), 0);
        end

        // FU2 stall: slot holds, entry not reselected, then frees; realloc in
        // the freeing cycle is an error
        do_reset();
        drive(A(10,2,0,1,0,1,0), NA, 0, 0, 0, 3'b000, 1'b0); step();
        idle(3'b000); step();
        chk("stall_iv0", 32'(issue_valid), 32'b100);
        for (int c = 0; c < 5; c++) begin
            idle(3'b000); step();
            chk($sformatf("stall%0d_iv", c), 32'(issue_valid), 32'b100);
            chk($sformatf("stall%0d_il", c), 32'(issue_line[11:8]), 10);
            chk($sformatf("stall%0d_fc", c), 32'(free_count), 15);
        end
        drive(A(10,2,0,1,0,1,1), NA, 0, 0, 0, 3'b100, 1'b0); step();
        chk("stall_rel_iv", 32'(issue_valid), 0);
        chk("stall_rel_fc", 32'(free_count), 16);
        chk("stall_rel_mask", 32'(free_mask), 32'hFFFF);
        chk("reuse_err", 32'(alloc_err), 1);
        idle(3'b000); step();
        chk("stall_after_iv", 32'(issue_valid), 0);

        // Fill 15 lines, then allocate onto an occupied line
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(A(4'(2*k),0,1,0,0,1,4'(2*k)), A(4'(2*k+1),0,1,0,0,1,4'(2*k+1)),
                  0, 0, 0, 3'b000, 1'b0);
            step();
        end
        chk("fc2_fc", 32'(free_count), 2);
        chk("fc2_full", 32'(rs_full), 0);
        drive(A(14,0,1,0,0,1,14), NA, 0, 0, 0, 3'b000, 1'b0); step();
        chk("full_fc", 32'(free_count), 1);
        chk("full_flag", 32'(rs_full), 1);
        chk("full_mask", 32'(free_mask), 32'h8000);
        chk("full_err0", 32'(alloc_err), 0);
        drive(A(5,1,0,1,0,1,15), NA, 0, 0, 0, 3'b000, 1'b0); step();
        chk("occ_err", 32'(alloc_err), 1);
        chk("occ_fc", 32'(free_count), 1);
        chk("occ_mask", 32'(free_mask), 32'h8000);
        idle(3'b000); step(); step();
        chk("occ_unchanged_iv", 32'(issue_valid), 0);

        // Illegal FU index
        do_reset();
        drive(A(0,3,0,1,0,1,0), NA, 0, 0, 0, 3'b000, 1'b0); step();
        chk("fu3_err", 32'(alloc_err), 1);
        chk("fu3_fc", 32'(free_count), 16);
        idle(3'b000); step();
        chk("fu3_iv", 32'(issue_valid), 0);

        // Same-line collision: port 1 wins
        do_reset();
        drive(A(0,0,0,1,0,1,0), A(0,1,0,1,0,1,1), 0, 0, 0, 3'b000, 1'b0); step();
        chk("dup_err", 32'(alloc_err), 1);
        chk("dup_fc", 32'(free_count), 15);
        idle(3'b000); step();
        chk("dup_iv", 32'(issue_valid), 32'b001);
        chk("dup_il", 32'(issue_line[3:0]), 0);

        // Flush with 8 waiting lines and 2 valid slots; alloc_err persists
        do_reset();
        drive(A(0,3,0,1,0,1,0), NA, 0, 0, 0, 3'b000, 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            drive(A(4'(2*k),1,1,0,0,1,4'(2*k)), A(4'(2*k+1),1,1,0,0,1,4'(2*k+1)),
                  0, 0, 0, 3'b000, 1'b0);
            step();
        end
        drive(A(8,0,0,1,0,1,8), A(9,2,0,1,0,1,9), 0, 0, 0, 3'b000, 1'b0); step();
        idle(3'b000); step();
        chk("pre_fl_iv", 32'(issue_valid), 32'b101);
        chk("pre_fl_il", 32'(issue_line & 12'hF0F), 32'h908);
        chk("pre_fl_fc", 32'(free_count), 6);
        drive(A(12,1,0,1,0,1,12), NA, 0, 0, 0, 3'b000, 1'b1); step();
        chk("fl_iv", 32'(issue_valid), 0);
        chk("fl_mask", 32'(free_mask), 32'hFFFF);
        chk("fl_fc", 32'(free_count), 16);
        chk("fl_full", 32'(rs_full), 0);
        chk("fl_err", 32'(alloc_err), 1);
        idle(3'b000); step();
        chk("post_fl_iv", 32'(issue_valid), 0);
        chk("post_fl_fc", 32'(free_count), 16);

        // Reset during an active handshake
        do_reset();
        drive(A(0,0,0,1,0,1,0), NA, 0, 0, 0, 3'b000, 1'b0); step();
        idle(3'b000); step();
        chk("mid_iv", 32'(issue_valid), 32'b001);
        idle(3'b001); rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_iv", 32'(issue_valid), 0);
        chk("mid_rst_il", 32'(issue_line), 0);
        chk("mid_rst_fc", 32'(free_count), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Wakeup/select scheduler for the 16-entry reservation station. It tracks per-entry occupancy and source readiness for entries written by dispatch, and wakes sources from writeback tag broadcasts. Each cycle it picks the oldest ready entry per functional unit (FU0/FU1 ALU, FU2 memory) and issues it over a valid/ready handshake. It sits between dispatch (allocation, free-entry reporting) and the three FUs.

## Interface
- RS_DEPTH, 16, reservation-station entries (line index width 4)
- PREG_W, 6, physical register tag width
- ROB_W, 4, ROB index width
- NUM_FU, 3, functional units; FU 2 is memory-only
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  synchronous clear of all entries and issue slots
- alloc_en_1, alloc_en_2  in  1 each  allocate request, port 1 / port 2
- alloc_line_1, alloc_line_2  in  4 each  RS line being written
- alloc_fu_1, alloc_fu_2  in  2 each  target FU index (0..2)
- alloc_ps1_x, alloc_ps2_x  in  6 each  source tags (x = 1, 2)
- alloc_rdy1_x, alloc_rdy2_x  in  1 each  source already ready at dispatch
- alloc_rob_x  in  4 each  ROB index of the instruction
- rob_head  in  4  current ROB head; used for age ordering
- wb_valid  in  3  per-FU writeback tag valid
- wb_pd  in  18  three packed 6-bit destination tags; FU f uses bits [6f+5:6f]
- fu_ready  in  3  FU f accepts an issue this cycle
- issue_valid  out  3  issue slot f holds an entry
- issue_line  out  12  three packed 4-bit RS line numbers
- free_mask  out  16  bit i = line i FREE
- free_count  out  5  number of FREE lines, 0..16
- rs_full  out  1  free_count < 2
- alloc_err  out  1  sticky protocol-error flag

## Operation
- Per-entry state is FREE, WAIT or ISSUED. Each entry also holds fu[1:0], ps1, ps2, rdy1, rdy2 and rob[3:0].
- **Allocate:** on alloc_en_x, the line goes FREE→WAIT and its fields are loaded.
  - If a source tag equals any valid wb_pd tag in the same cycle, its rdy bit loads as 1 (wakeup bypass).
- **Allocation errors** set alloc_err and the offending request is ignored:
  - the target line is not FREE in the registered state;
  - alloc_fu_x == 3;
  - both ports enabled on the same line — port 1 wins, port 2 is dropped.
- **Wakeup:** every WAIT entry whose ps1/ps2 matches a valid wb_pd tag sets rdy1/rdy2 at the clock edge. Multiple matches are allowed.
- **Readiness:** an entry is eligible when state==WAIT and rdy1 && rdy2, using registered values only.
- **Age order:** age = (rob − rob_head) mod 16, unsigned 4-bit; smaller is older. ROB indices are unique, so there are no ties.
- **Select:** slot f is loadable when issue_valid[f]==0, or issue_valid[f] && fu_ready[f]. A loadable slot takes the oldest eligible entry with fu==f. That entry goes WAIT→ISSUED and issue_line[f] is set to its line.
- **Handshake:** when issue_valid[f] && fu_ready[f], the entry at issue_line[f] goes ISSUED→FREE and the slot is cleared or reloaded in the same edge. While fu_ready[f]==0, issue_valid and issue_line hold stable.
- **Counters:** free_count and free_mask are registered from next-state.
- **Priority:** rst > flush > (handshake free, select, allocate, wakeup). The last four act on disjoint entries or fields in one edge.
- **flush:** all entries FREE, issue_valid = 0, alloc_err unchanged, all allocs that cycle ignored.

## Timing
- **Reset values:** issue_valid = 0, issue_line = 0, free_mask = 16'hFFFF, free_count = 16, rs_full = 0, alloc_err = 0, all entries FREE.
- **Alloc with both sources ready:** alloc at edge N; eligible in cycle N+1; issue_valid high after edge N+1 (2-cycle alloc-to-issue).
- **Wakeup:** broadcast in cycle N; entry selectable in N+1; issue_valid after edge N+1.
- **Back-to-back issue:** with fu_ready held high, one issue per FU per cycle.
- **Line reuse:** a line freed at edge N shows in free_mask from cycle N+1. Allocating it in cycle N is an error.
- **Full:** rs_full asserts when free_count ≤ 1. Dispatch must not allocate more lines than free_count.
- **Reset mid-handshake:** drops the slot without freeing semantics; all state is simply reinitialised.

## Test plan
- Reset, then two allocs (line 0 FU0, line 1 FU1, all rdy = 1) -> 2 cycles later issue_valid = 3'b011, issue_line = {x, 1, 0}; free_count 16→14→16 after both handshakes.
- Alloc line 3 FU0 with rdy1 = 0, ps1 = 6'd9; wb_valid[1] = 1, wb_pd = 9 three cycles later -> issue_valid[0] rises exactly 2 cycles after the broadcast.
- rob_head = 14; ready FU0 entries with rob 15, 2, 13 -> issue order rob 15, 2, 13 with fu_ready[0] = 1 each cycle.
- FU2 entry issued, fu_ready[2] = 0 for 5 cycles -> issue_valid[2] and issue_line[2] stable, entry not reselected; frees on first fu_ready.
- Fill 15 lines -> rs_full = 1, free_count = 1; alloc onto an occupied line -> alloc_err = 1, entry unchanged.
- Flush with 8 WAIT entries and 2 valid slots -> next cycle issue_valid = 0, free_mask = 16'hFFFF, free_count = 16.
